// File: rtl/mouse_cell_capture.sv
// mouse_cell_capture: locks onto the grid cell under the first pen-down pixel and records its stroke bitmap until a pen-up timeout
module mouse_cell_capture #(
  parameter int CELL = 52,
  parameter int GRID_N = 9,
  parameter int ORG_X = 160,
  parameter int ORG_Y = 0,
  parameter int SCREENW = 640,
  parameter int SCREENH = 480,
  parameter int MIRROR = 1,
  parameter int TIMEOUT = 50000000,
  localparam int CW = $clog2(GRID_N + 1),
  localparam int NB = CELL * CELL,
  localparam int PW = $clog2(NB + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    MOUSE_X_POS,
  input  logic [9:0]    MOUSE_Y_POS,
  input  logic          MOUSE_LEFT,
  input  logic          clear,
  input  logic          ready,
  output logic          valid,
  output logic [NB-1:0] track,
  output logic [CW-1:0] cell_x,
  output logic [CW-1:0] cell_y,
  output logic          busy,
  output logic [PW-1:0] pix_cnt
);
  localparam int IW = $clog2(NB);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SPAN = GRID_N * CELL;
  typedef enum logic [1:0] {IDLE, DRAW, HOLD} state_t;
  state_t r_state, w_next;
  logic [NB-1:0] r_track;
  logic [PW-1:0] r_pix;
  logic [TW-1:0] r_cnt;
  logic [CW-1:0] r_cell_x, r_cell_y, w_cx, w_cy;
  logic [12:0] w_x, w_y, w_dx, w_dy, w_rx, w_ry;
  logic [IW-1:0] w_idx;
  logic w_in_grid, w_in_cell, w_rec, w_timeout;
  assign w_x = MIRROR != 0 ? 13'(SCREENW - 1) - 13'(MOUSE_X_POS) : 13'(MOUSE_X_POS);
  assign w_y = MIRROR != 0 ? 13'(SCREENH - 1) - 13'(MOUSE_Y_POS) : 13'(MOUSE_Y_POS);
  assign w_dx = w_x - 13'(ORG_X);
  assign w_dy = w_y - 13'(ORG_Y);
  assign w_in_grid = !w_dx[12] && !w_dy[12] && w_dx < 13'(SPAN) && w_dy < 13'(SPAN);
  assign w_cx = CW'(w_dx / 13'(CELL));
  assign w_cy = CW'(w_dy / 13'(CELL));
  assign w_rx = w_dx % 13'(CELL);
  assign w_ry = w_dy % 13'(CELL);
  assign w_idx = IW'(w_ry * 13'(CELL) + w_rx);
  assign w_in_cell = w_in_grid && w_cx == r_cell_x && w_cy == r_cell_y;
  assign w_rec = MOUSE_LEFT && (r_state == IDLE ? w_in_grid : r_state == DRAW && w_in_cell);
  assign w_timeout = r_state == DRAW && !MOUSE_LEFT && r_cnt == TW'(TIMEOUT - 1);
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  always_comb
    w_next = clear ? IDLE :
             r_state == IDLE ? (MOUSE_LEFT && w_in_grid ? DRAW : IDLE) :
             r_state == DRAW ? (w_timeout ? HOLD : DRAW) :
             (ready ? IDLE : HOLD);
  always_comb begin
    valid = r_state == HOLD;
    busy = r_state == DRAW;
    track = r_track;
    cell_x = r_cell_x;
    cell_y = r_cell_y;
    pix_cnt = r_pix;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_track <= '0;
      r_pix <= '0;
      r_cnt <= '0;
      r_cell_x <= '0;
      r_cell_y <= '0;
    end else if (clear || (r_state == HOLD && ready)) begin
      r_track <= '0;
      r_pix <= '0;
      r_cnt <= '0;
    end else begin
      if (r_state == IDLE && MOUSE_LEFT && w_in_grid) begin
        r_cell_x <= w_cx;
        r_cell_y <= w_cy;
      end
      if (w_rec) r_track[w_idx] <= 1'b1;
      if (w_rec && !r_track[w_idx] && r_pix != PW'(NB)) r_pix <= r_pix + 1'b1;
      r_cnt <= r_state == DRAW && !MOUSE_LEFT ? r_cnt + 1'b1 : '0;
    end
  end
endmodule

// File: tb/tb_mouse_cell_capture.sv
// tb_mouse_cell_capture: directed and randomized checks of the capture block against a behavioural model
module tb_mouse_cell_capture;
  localparam int CELL = 52;
  localparam int GRID_N = 9;
  localparam int ORG_X = 160;
  localparam int ORG_Y = 0;
  localparam int SW = 640;
  localparam int SH = 480;
  localparam int TO = 8;
  localparam int NB = CELL * CELL;
  logic clk = 0, rst = 1, ml = 0, clear = 0, ready = 0;
  logic [9:0] mx = 0, my = 0;
  logic valid, busy;
  logic [NB-1:0] track;
  logic [3:0] cell_x, cell_y;
  logic [11:0] pix_cnt;
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;
  int m_mode = 0, m_cx = 0, m_cy = 0, m_run = 0;
  bit [NB-1:0] m_trk = '0;
  int cxr = 200, cyr = 200;
  always #5 clk = ~clk;
  mouse_cell_capture #(
    .CELL(CELL), .GRID_N(GRID_N), .ORG_X(ORG_X), .ORG_Y(ORG_Y),
    .SCREENW(SW), .SCREENH(SH), .MIRROR(1), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .MOUSE_X_POS(mx), .MOUSE_Y_POS(my), .MOUSE_LEFT(ml),
    .clear(clear), .ready(ready), .valid(valid), .track(track),
    .cell_x(cell_x), .cell_y(cell_y), .busy(busy), .pix_cnt(pix_cnt)
  );
  task automatic chk(input string n, input longint a, input longint e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  task automatic chk_trk(input string n, input logic [NB-1:0] e);
    n_cmp++;
    if (track !== e) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %0d set bits expected %0d set bits at %0t", n, $countones(track), $countones(e), $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #3;
  endtask
  task automatic px(input int x, input int y);
    mx = 10'(SW - 1 - x);
    my = 10'(SH - 1 - y);
  endtask
  always @(posedge clk) begin
    int x, y, cx, cy, idx;
    bit ing;
    x = SW - 1 - int'(mx);
    y = SH - 1 - int'(my);
    ing = x >= ORG_X && x < ORG_X + GRID_N * CELL && y >= ORG_Y && y < ORG_Y + GRID_N * CELL;
    cx = ing ? (x - ORG_X) / CELL : -1;
    cy = ing ? (y - ORG_Y) / CELL : -1;
    idx = ing ? ((y - ORG_Y) % CELL) * CELL + (x - ORG_X) % CELL : 0;
    if (rst) begin
      m_mode = 0; m_trk = '0; m_cx = 0; m_cy = 0; m_run = 0;
    end else if (clear) begin
      m_mode = 0; m_trk = '0; m_run = 0;
    end else if (m_mode == 0) begin
      if (ml && ing) begin
        m_mode = 1; m_cx = cx; m_cy = cy; m_trk[idx] = 1'b1; m_run = 0;
      end
    end else if (m_mode == 1) begin
      if (ml && cx == m_cx && cy == m_cy) m_trk[idx] = 1'b1;
      m_run = ml ? 0 : m_run + 1;
      if (m_run == TO) m_mode = 2;
    end else if (ready) begin
      m_mode = 0; m_trk = '0;
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", valid, m_mode == 2);
      chk("busy", busy, m_mode == 1);
      chk("cell_x", cell_x, m_cx);
      chk("cell_y", cell_y, m_cy);
      chk("pix_cnt", pix_cnt, $countones(m_trk));
      chk_trk("track", m_trk);
    end
  end
  initial begin
    tick();
    tick();
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pix", pix_cnt, 0);
    chk("rst_cell_x", cell_x, 0);
    chk("rst_track_ones", $countones(track), 0);
    rst = 0;
    chk_en = 1;
    mx = 479; my = 479; ml = 1;
    tick();
    chk("p1_busy", busy, 1);
    chk("p1_cell_x", cell_x, 0);
    chk("p1_cell_y", cell_y, 0);
    chk("p1_bit0", track[0], 1);
    chk("p1_pix", pix_cnt, 1);
    ml = 0;
    repeat (7) tick();
    chk("p1_valid_early", valid, 0);
    tick();
    chk("p1_valid", valid, 1);
    chk("p1_busy_hold", busy, 0);
    ready = 1;
    tick();
    ready = 0;
    chk("p1_release_valid", valid, 0);
    chk("p1_release_ones", $countones(track), 0);
    mx = 11; my = 11; ml = 1;
    repeat (3) tick();
    chk("out_busy", busy, 0);
    chk("out_ones", $countones(track), 0);
    ml = 0;
    tick();
    px(576, 416); ml = 1;
    tick();
    chk("c88_cell_x", cell_x, 8);
    chk("c88_cell_y", cell_y, 8);
    chk("c88_bit0", track[0], 1);
    px(575, 416);
    repeat (3) tick();
    chk("drag_pix", pix_cnt, 1);
    chk("drag_cell_x", cell_x, 8);
    chk("drag_ones", $countones(track), 1);
    px(576, 416);
    repeat (20) tick();
    ml = 0;
    repeat (7) tick();
    ml = 1;
    tick();
    chk("repress_valid", valid, 0);
    chk("repress_busy", busy, 1);
    chk("repress_pix", pix_cnt, 1);
    ml = 0;
    repeat (8) tick();
    chk("hold_valid", valid, 1);
    repeat (100) begin
      ml = 1'($urandom);
      mx = 10'($urandom_range(0, 1023));
      my = 10'($urandom_range(0, 1023));
      tick();
    end
    chk("stall_valid", valid, 1);
    chk("stall_pix", pix_cnt, 1);
    chk("stall_cell_y", cell_y, 8);
    ml = 0; ready = 1;
    tick();
    ready = 0;
    chk("stall_exit_valid", valid, 0);
    chk("stall_exit_ones", $countones(track), 0);
    px(269, 163); ml = 1;
    repeat (3) tick();
    clear = 1;
    tick();
    clear = 0; ml = 0;
    chk("clr_busy", busy, 0);
    chk("clr_pix", pix_cnt, 0);
    chk("clr_cell_x", cell_x, 2);
    chk("clr_cell_y", cell_y, 3);
    ml = 1;
    tick();
    ml = 0;
    repeat (7) tick();
    clear = 1;
    tick();
    clear = 0;
    chk("clr_vs_timeout_valid", valid, 0);
    chk("clr_vs_timeout_busy", busy, 0);
    ml = 1;
    tick();
    ml = 0;
    repeat (8) tick();
    chk("hold2_valid", valid, 1);
    ready = 1; rst = 1;
    tick();
    rst = 0; ready = 0;
    chk("rst_hold_valid", valid, 0);
    chk("rst_hold_busy", busy, 0);
    chk("rst_hold_pix", pix_cnt, 0);
    chk("rst_hold_cell_x", cell_x, 0);
    chk("rst_hold_cell_y", cell_y, 0);
    chk("rst_hold_ones", $countones(track), 0);
    for (int s = 0; s < 400; s++) begin
      int len;
      bit l;
      len = int'($urandom_range(1, 12));
      l = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 7) == 0) begin
        cxr = int'($urandom_range(0, 520));
        cyr = int'($urandom_range(0, 520));
      end
      for (int k = 0; k < len; k++) begin
        ml = l;
        mx = 10'(cxr + int'($urandom_range(0, 30)));
        my = 10'(cyr + int'($urandom_range(0, 30)));
        ready = $urandom_range(0, 3) == 0;
        clear = $urandom_range(0, 150) == 0;
        rst = $urandom_range(0, 700) == 0;
        tick();
      end
    end
    rst = 0; clear = 0; ready = 0; ml = 0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
